// File: rtl/dcache_lsu.sv
// Data-memory load/store unit: byte/half/word accesses with sign/zero
// extension, a pipelined read path of RD_LAT cycles and a post-reset clear sweep.
module dcache_lsu #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int          RD_LAT    = 1,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r_ena,
  input  logic        w_ena,
  input  logic [31:0] addr,
  input  logic [1:0]  width,
  input  logic        uns,
  input  logic [31:0] data_in,
  output logic        ready,
  output logic        valid,
  output logic [31:0] data_out,
  output logic        fault
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W = DEPTH;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic [0:0] {INIT, RUN} state_t;

  typedef struct packed {
    logic        vld;
    logic        flt;
    logic [31:0] word;
    logic [1:0]  lane;
    logic [1:0]  width;
    logic        uns;
  } ld_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   sweep_cnt;
  logic [31:0]     mem [DEPTH];

  logic [31:0]     word_off;
  logic [AW-1:0]   idx;
  logic            misalign, bad, acc, ld_acc, st_acc;
  logic [3:0]      be;
  logic [31:0]     wdata;
  ld_t             s0, last;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= INIT_ZERO ? INIT : RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && sweep_cnt == LAST) state_nxt = RUN;
  end

  // ready is forced low while rst is held, even when reset lands directly in RUN
  always_comb begin
    ready = (state == RUN) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst)                                    sweep_cnt <= '0;
    else if (state == INIT && sweep_cnt != LAST) sweep_cnt <= sweep_cnt + 1'b1;
  end

  // ---------------- request decode ----------------
  assign word_off = (addr - BASE_ADDR) >> 2;
  assign idx      = word_off[AW-1:0];
  assign misalign = (width == 2'b11) || (width == 2'b01 && addr[0]) ||
                    (width == 2'b10 && addr[1:0] != 2'b00);
  assign bad      = misalign || (addr < BASE_ADDR) || (word_off >= DEPTH_W);
  assign acc      = (r_ena || w_ena) && ready;
  assign st_acc   = acc && w_ena;
  assign ld_acc   = acc && r_ena && !w_ena;

  always_comb begin
    be    = 4'h0;
    wdata = data_in;
    case (width)
      2'b00: begin
        be[addr[1:0]] = 1'b1;
        wdata         = {4{data_in[7:0]}};
      end
      2'b01: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data_in[15:0]}};
      end
      default: be = 4'hF;
    endcase
  end

  // Stores land on the acceptance edge, so a load in the next cycle sees them.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[sweep_cnt] <= '0;
    end else if (st_acc && !bad) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // ---------------- read pipeline ----------------
  always_comb begin
    s0.vld   = ld_acc && !bad;
    s0.flt   = ld_acc && bad;
    s0.word  = mem[idx];
    s0.lane  = addr[1:0];
    s0.width = width;
    s0.uns   = uns;
  end

  generate
    if (RD_LAT == 1) begin : g_nopipe
      assign last = s0;
    end else begin : g_pipe
      ld_t vld_pipe [RD_LAT-1];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < RD_LAT-1; k++) vld_pipe[k] <= '0;
        end else begin
          vld_pipe[0] <= s0;
          for (int k = 1; k < RD_LAT-1; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
      end
      assign last = vld_pipe[RD_LAT-2];
    end
  endgenerate

  function automatic logic [31:0] extend(ld_t s);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = s.word >> {s.lane, 3'b000};
    b  = sh[7:0];
    h  = s.lane[1] ? s.word[31:16] : s.word[15:0];
    case (s.width)
      2'b00:   extend = s.uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   extend = s.uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: extend = s.word;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      fault    <= 1'b0;
      data_out <= '0;
    end else begin
      valid <= last.vld;
      fault <= last.flt || (st_acc && bad);
      if (last.vld) data_out <= extend(last);
    end
  end
endmodule

// File: tb/tb_dcache_lsu.sv
// Directed bench: three DUTs (RD_LAT 1..3, DEPTH 16) share one stimulus stream
// and are each checked against hand-computed responses at their own latency.
module tb_dcache_lsu;
  localparam logic [31:0] B = 32'h1001_0000;

  typedef struct {
    string       nm;
    logic        r, w;
    logic [31:0] a;
    logic [1:0]  wd;
    logic        u;
    logic [31:0] d;
    logic [31:0] exp;
    logic        flt;
  } vec_t;

  logic        clk, rst, r_ena, w_ena, uns;
  logic [31:0] addr, data_in;
  logic [1:0]  width;
  logic        rdy [1:3];
  logic        vld [1:3];
  logic        flt [1:3];
  logic [31:0] dout [1:3];

  int total = 0;
  int bad   = 0;

  genvar g;
  generate
    for (g = 1; g <= 3; g++) begin : g_dut
      dcache_lsu #(.DEPTH(16), .BASE_ADDR(B), .RD_LAT(g), .INIT_ZERO(1'b1)) u_dut (
        .clk(clk), .rst(rst), .r_ena(r_ena), .w_ena(w_ena), .addr(addr),
        .width(width), .uns(uns), .data_in(data_in), .ready(rdy[g]),
        .valid(vld[g]), .data_out(dout[g]), .fault(flt[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    r_ena = 0; w_ena = 0; addr = '0; width = 2'b00; uns = 0; data_in = '0;
  endtask

  task automatic drive(vec_t v);
    r_ena = v.r; w_ena = v.w; addr = v.a; width = v.wd; uns = v.u; data_in = v.d;
  endtask

  function automatic vec_t mk(string nm, logic r, logic w, logic [31:0] a, logic [1:0] wd,
                              logic u, logic [31:0] d, logic [31:0] exp, logic f);
    vec_t v;
    v.nm = nm; v.r = r; v.w = w; v.a = a; v.wd = wd; v.u = u; v.d = d; v.exp = exp; v.flt = f;
    return v;
  endfunction

  // One request, then idle; check each DUT's valid/fault/data over 4 cycles.
  task automatic run_vec(vec_t v);
    drive(v);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      for (int i = 1; i <= 3; i++) begin
        logic ev, ef;
        ev = v.r && !v.w && !v.flt && (k == i);
        ef = v.flt && (k == (v.w ? 1 : i));
        chk($sformatf("%s L%0d k%0d valid", v.nm, i, k), 32'(vld[i]), 32'(ev));
        chk($sformatf("%s L%0d k%0d fault", v.nm, i, k), 32'(flt[i]), 32'(ef));
        if (ev) chk($sformatf("%s L%0d data", v.nm, i), dout[i], v.exp);
      end
      if (k == 1) idle();
    end
  endtask

  task automatic sweep_wait(string nm, int poke_at);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      idle();
      for (int j = 1; j <= 3; j++)
        chk($sformatf("%s ready c%0d L%0d", nm, i, j), 32'(rdy[j]), 32'(i == 16));
      if (i == poke_at) drive(mk("poke", 1'b0, 1'b1, B + 32'h20, 2'b10, 1'b0, 32'hFFFF_FFFF, 0, 0));
    end
  endtask

  vec_t tv[$];
  logic [31:0] pl_a [4];
  logic [31:0] pl_e [4];

  initial begin
    idle();
    rst = 1;
    repeat (3) @(negedge clk);
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("rst ready L%0d", i), 32'(rdy[i]), 0);
      chk($sformatf("rst valid L%0d", i), 32'(vld[i]), 0);
      chk($sformatf("rst fault L%0d", i), 32'(flt[i]), 0);
      chk($sformatf("rst data L%0d", i), dout[i], 0);
    end
    rst = 0;
    sweep_wait("init", 0);

    for (int i = 0; i < 16; i++)
      tv.push_back(mk($sformatf("clr%0d", i), 1, 0, B + 32'(4*i), 2'b10, 0, 0, 0, 0));
    tv.push_back(mk("st_w8",   0, 1, B + 32'h08, 2'b10, 0, 32'h80FF_7F01, 0, 0));
    tv.push_back(mk("lb8",     1, 0, B + 32'h08, 2'b00, 0, 0, 32'h0000_0001, 0));
    tv.push_back(mk("lb9",     1, 0, B + 32'h09, 2'b00, 0, 0, 32'h0000_007F, 0));
    tv.push_back(mk("lbA",     1, 0, B + 32'h0A, 2'b00, 0, 0, 32'hFFFF_FFFF, 0));
    tv.push_back(mk("lbB",     1, 0, B + 32'h0B, 2'b00, 0, 0, 32'hFFFF_FF80, 0));
    tv.push_back(mk("lbuA",    1, 0, B + 32'h0A, 2'b00, 1, 0, 32'h0000_00FF, 0));
    tv.push_back(mk("lhA",     1, 0, B + 32'h0A, 2'b01, 0, 0, 32'hFFFF_80FF, 0));
    tv.push_back(mk("lhuA",    1, 0, B + 32'h0A, 2'b01, 1, 0, 32'h0000_80FF, 0));
    tv.push_back(mk("lh8",     1, 0, B + 32'h08, 2'b01, 0, 0, 32'h0000_7F01, 0));
    tv.push_back(mk("lwu8",    1, 0, B + 32'h08, 2'b10, 1, 0, 32'h80FF_7F01, 0));
    tv.push_back(mk("f_lh1",   1, 0, B + 32'h01, 2'b01, 0, 0, 0, 1));
    tv.push_back(mk("f_sw2",   0, 1, B + 32'h02, 2'b10, 0, 32'hDEAD_BEEF, 0, 1));
    tv.push_back(mk("f_w11",   1, 0, B + 32'h08, 2'b11, 0, 0, 0, 1));
    tv.push_back(mk("f_low",   1, 0, 32'h1000_FFFC, 2'b10, 0, 0, 0, 1));
    tv.push_back(mk("f_high",  1, 0, B + 32'h40, 2'b10, 0, 0, 0, 1));
    tv.push_back(mk("f_sbhi",  0, 1, B + 32'h40, 2'b00, 0, 32'h55, 0, 1));
    tv.push_back(mk("keep0",   1, 0, B + 32'h00, 2'b10, 0, 0, 32'h0000_0000, 0));
    tv.push_back(mk("keep8",   1, 0, B + 32'h08, 2'b10, 0, 0, 32'h80FF_7F01, 0));
    tv.push_back(mk("st_hE",   0, 1, B + 32'h0E, 2'b01, 0, 32'hFFFF_1234, 0, 0));
    tv.push_back(mk("st_bC",   0, 1, B + 32'h0C, 2'b00, 0, 32'hFFFF_FF56, 0, 0));
    tv.push_back(mk("lwC",     1, 0, B + 32'h0C, 2'b10, 0, 0, 32'h1234_0056, 0));
    tv.push_back(mk("lhuE",    1, 0, B + 32'h0E, 2'b01, 1, 0, 32'h0000_1234, 0));
    tv.push_back(mk("lbC",     1, 0, B + 32'h0C, 2'b00, 0, 0, 32'h0000_0056, 0));
    tv.push_back(mk("rw_st",   1, 1, B + 32'h10, 2'b00, 0, 32'h77, 0, 0));
    tv.push_back(mk("lw10",    1, 0, B + 32'h10, 2'b10, 0, 0, 32'h0000_0077, 0));
    tv.push_back(mk("st_w3C",  0, 1, B + 32'h3C, 2'b10, 0, 32'hCAFE_F00D, 0, 0));
    tv.push_back(mk("lw3C",    1, 0, B + 32'h3C, 2'b10, 0, 0, 32'hCAFE_F00D, 0));
    foreach (tv[i]) run_vec(tv[i]);

    // store then load of the same word on the very next cycle
    drive(mk("raw_st", 0, 1, B + 32'h05, 2'b00, 0, 32'hAB, 0, 0));
    @(negedge clk);
    for (int i = 1; i <= 3; i++) chk($sformatf("raw st valid L%0d", i), 32'(vld[i]), 0);
    drive(mk("raw_ld", 1, 0, B + 32'h04, 2'b10, 0, 0, 0, 0));
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      idle();
      for (int i = 1; i <= 3; i++) begin
        chk($sformatf("raw L%0d k%0d valid", i, k), 32'(vld[i]), 32'(k == 1 + i));
        if (k == 1 + i) chk($sformatf("raw L%0d data", i), dout[i], 32'h0000_AB00);
      end
    end

    // back-to-back loads of four distinct words
    pl_a = '{B + 32'h08, B + 32'h0C, B + 32'h10, B + 32'h3C};
    pl_e = '{32'h80FF_7F01, 32'h1234_0056, 32'h0000_0077, 32'hCAFE_F00D};
    drive(mk("pl", 1, 0, pl_a[0], 2'b10, 0, 0, 0, 0));
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      for (int i = 1; i <= 3; i++) begin
        int n;
        n = k - i;
        chk($sformatf("pipe L%0d k%0d valid", i, k), 32'(vld[i]), 32'(n >= 0 && n < 4));
        if (n >= 0 && n < 4) chk($sformatf("pipe L%0d k%0d data", i, k), dout[i], pl_e[n]);
      end
      if (k < 4) drive(mk("pl", 1, 0, pl_a[k], 2'b10, 0, 0, 0, 0));
      else       idle();
    end

    // reset one cycle after a load issue drops it
    drive(mk("rl", 1, 0, B + 32'h08, 2'b10, 0, 0, 0, 0));
    @(negedge clk);
    chk("rstld L1 valid", 32'(vld[1]), 1);
    idle();
    rst = 1;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      for (int i = 2; i <= 3; i++) begin
        chk($sformatf("rstld L%0d k%0d valid", i, k), 32'(vld[i]), 0);
        chk($sformatf("rstld L%0d k%0d fault", i, k), 32'(flt[i]), 0);
        chk($sformatf("rstld L%0d k%0d data", i, k), dout[i], 0);
      end
    end

    // reset mid-sweep restarts it; a store while not ready is ignored
    rst = 0;
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    sweep_wait("resweep", 12);
    run_vec(mk("ign20", 1, 0, B + 32'h20, 2'b10, 0, 0, 0, 0));
    run_vec(mk("clr8",  1, 0, B + 32'h08, 2'b10, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
